dram_arb: RTL and testbench

Two-requester arbiter in front of the DRAM controller's bus-side port, in the `clk_core` domain. Requesters are m0 (instruction refill) and m1 (data refill/writeback). It grants the controller's command, write-data and read-data channels to one requester for one whole burst, using round-robin priority. A burst-length protocol checker raises a sticky error.

---
 rtl/dram_arb.sv | 186 ++++++++++++++++++
 tb/tb_dram_arb.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_arb.sv
// Two-requester round-robin arbiter in front of the DRAM controller bus port.
// One requester owns the command, write and read channels for a whole burst.
module dram_arb #(
   parameter int MAX_BEATS = 16,
   parameter int CNT_W     = $clog2(MAX_BEATS + 1)
) (
   input  logic        clk_core,
   input  logic        reset,
   input  logic        m0_cvalid,
   output logic        m0_cready,
   input  logic        m0_cmd,
   input  logic [25:0] m0_addr,
   input  logic        m0_wvalid,
   output logic        m0_wready,
   input  logic        m0_wlast,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_wmask,
   output logic        m0_rvalid,
   input  logic        m0_rready,
   output logic        m0_rlast,
   output logic [31:0] m0_rdata,
   input  logic        m1_cvalid,
   output logic        m1_cready,
   input  logic        m1_cmd,
   input  logic [25:0] m1_addr,
   input  logic        m1_wvalid,
   output logic        m1_wready,
   input  logic        m1_wlast,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_wmask,
   output logic        m1_rvalid,
   input  logic        m1_rready,
   output logic        m1_rlast,
   output logic [31:0] m1_rdata,
   output logic        arb_cvalid,
   input  logic        dctl_cready,
   output logic        arb_cmd,
   output logic [25:0] arb_addr,
   output logic        arb_wvalid,
   input  logic        dctl_wready,
   output logic        arb_wlast,
   output logic [31:0] arb_wdata,
   output logic [3:0]  arb_wmask,
   input  logic        dctl_rvalid,
   output logic        arb_rready,
   input  logic        dctl_rlast,
   input  logic [31:0] dctl_rdata,
   input  logic        dctl_error,
   output logic [1:0]  arb_grant,
   output logic        arb_error
);

   typedef enum logic [1:0] {S_IDLE, S_CMD, S_WDATA, S_RDATA} state_t;

   state_t           r_state, w_state_next;
   logic [1:0]       r_grant, w_grant_next;
   logic             r_prio, w_prio_next;
   logic [CNT_W-1:0] r_beat_cnt, w_beat_cnt_next;
   logic             r_err, w_err_next;

   logic             w_sel_m1;
   logic             w_g_cvalid, w_g_cmd, w_g_wvalid, w_g_wlast, w_g_rready;
   logic [25:0]      w_g_addr;
   logic [31:0]      w_g_wdata;
   logic [3:0]       w_g_wmask;
   logic             w_in_cmd, w_in_wdata, w_in_rdata;
   logic             w_cmd_hs, w_wbeat, w_rbeat, w_beat, w_at_max;

   // Data buses default to m0 whenever m1 is not the owner (including idle).
   assign w_sel_m1   = r_grant[1];
   assign w_g_cvalid = w_sel_m1 ? m1_cvalid : m0_cvalid;
   assign w_g_cmd    = w_sel_m1 ? m1_cmd    : m0_cmd;
   assign w_g_addr   = w_sel_m1 ? m1_addr   : m0_addr;
   assign w_g_wvalid = w_sel_m1 ? m1_wvalid : m0_wvalid;
   assign w_g_wlast  = w_sel_m1 ? m1_wlast  : m0_wlast;
   assign w_g_wdata  = w_sel_m1 ? m1_wdata  : m0_wdata;
   assign w_g_wmask  = w_sel_m1 ? m1_wmask  : m0_wmask;
   assign w_g_rready = w_sel_m1 ? m1_rready : m0_rready;

   assign w_in_cmd   = (r_state == S_CMD);
   assign w_in_wdata = (r_state == S_WDATA);
   assign w_in_rdata = (r_state == S_RDATA);

   assign arb_cvalid = w_in_cmd & w_g_cvalid;
   assign arb_cmd    = w_g_cmd;
   assign arb_addr   = w_g_addr;
   assign m0_cready  = w_in_cmd & r_grant[0] & dctl_cready;
   assign m1_cready  = w_in_cmd & r_grant[1] & dctl_cready;

   assign arb_wvalid = w_in_wdata & w_g_wvalid;
   assign arb_wlast  = w_g_wlast;
   assign arb_wdata  = w_g_wdata;
   assign arb_wmask  = w_g_wmask;
   assign m0_wready  = w_in_wdata & r_grant[0] & dctl_wready;
   assign m1_wready  = w_in_wdata & r_grant[1] & dctl_wready;

   assign arb_rready = w_in_rdata & w_g_rready;
   assign m0_rvalid  = w_in_rdata & r_grant[0] & dctl_rvalid;
   assign m1_rvalid  = w_in_rdata & r_grant[1] & dctl_rvalid;
   assign m0_rlast   = m0_rvalid & dctl_rlast;
   assign m1_rlast   = m1_rvalid & dctl_rlast;
   assign m0_rdata   = dctl_rdata;
   assign m1_rdata   = dctl_rdata;

   assign arb_grant  = r_grant;
   assign arb_error  = r_err | dctl_error;

   assign w_cmd_hs = arb_cvalid & dctl_cready;
   assign w_wbeat  = arb_wvalid & dctl_wready;
   assign w_rbeat  = arb_rready & dctl_rvalid;
   assign w_beat   = w_wbeat | w_rbeat;
   assign w_at_max = (r_beat_cnt == CNT_W'(MAX_BEATS));

   always_comb begin
      w_state_next    = r_state;
      w_grant_next    = r_grant;
      w_prio_next     = r_prio;
      w_beat_cnt_next = r_beat_cnt;
      w_err_next      = r_err;

      case (r_state)
         S_IDLE: begin
            w_beat_cnt_next = '0;
            if (m0_cvalid | m1_cvalid) begin
               if (m0_cvalid & m1_cvalid)
                  w_grant_next = r_prio ? 2'b10 : 2'b01;
               else
                  w_grant_next = m1_cvalid ? 2'b10 : 2'b01;
               w_state_next = S_CMD;
            end
         end
         S_CMD: begin
            if (w_cmd_hs)
               w_state_next = w_g_cmd ? S_RDATA : S_WDATA;
         end
         S_WDATA: begin
            if (w_wbeat) begin
               if (!w_at_max)
                  w_beat_cnt_next = r_beat_cnt + CNT_W'(1);
               if (w_g_wlast) begin
                  w_state_next = S_IDLE;
                  w_grant_next = 2'b00;
                  w_prio_next  = r_grant[0];
               end
            end
         end
         S_RDATA: begin
            if (w_rbeat) begin
               if (!w_at_max)
                  w_beat_cnt_next = r_beat_cnt + CNT_W'(1);
               if (dctl_rlast) begin
                  w_state_next = S_IDLE;
                  w_grant_next = 2'b00;
                  w_prio_next  = r_grant[0];
               end
            end
         end
         default: w_state_next = S_IDLE;
      endcase

      // Odd post-increment count on wlast means the pre-increment count was even.
      if (w_wbeat & w_g_wlast & ~r_beat_cnt[0])
         w_err_next = 1'b1;
      if (w_beat & w_at_max)
         w_err_next = 1'b1;
      if (dctl_rvalid & ~w_in_rdata)
         w_err_next = 1'b1;
   end

   always_ff @(posedge clk_core or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_grant    <= 2'b00;
         r_prio     <= 1'b0;
         r_beat_cnt <= '0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_grant    <= w_grant_next;
         r_prio     <= w_prio_next;
         r_beat_cnt <= w_beat_cnt_next;
         r_err      <= w_err_next;
      end
   end

endmodule

// File: tb/tb_dram_arb.sv
// Directed bench for dram_arb: grants, round-robin order, pass-through data,
// stalls, protocol-error cases and asynchronous reset.
module tb_dram_arb;

   logic        clk_core = 1'b0;
   logic        reset;
   logic        m0_cvalid, m0_cready, m0_cmd, m0_wvalid, m0_wready, m0_wlast;
   logic        m0_rvalid, m0_rready, m0_rlast;
   logic [25:0] m0_addr;
   logic [31:0] m0_wdata, m0_rdata;
   logic [3:0]  m0_wmask;
   logic        m1_cvalid, m1_cready, m1_cmd, m1_wvalid, m1_wready, m1_wlast;
   logic        m1_rvalid, m1_rready, m1_rlast;
   logic [25:0] m1_addr;
   logic [31:0] m1_wdata, m1_rdata;
   logic [3:0]  m1_wmask;
   logic        arb_cvalid, dctl_cready, arb_cmd, arb_wvalid, dctl_wready, arb_wlast;
   logic [25:0] arb_addr;
   logic [31:0] arb_wdata, dctl_rdata;
   logic [3:0]  arb_wmask;
   logic        dctl_rvalid, arb_rready, dctl_rlast, dctl_error, arb_error;
   logic [1:0]  arb_grant;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk_core = ~clk_core;

   dram_arb #(.MAX_BEATS(16)) dut (
      .clk_core(clk_core), .reset(reset),
      .m0_cvalid(m0_cvalid), .m0_cready(m0_cready), .m0_cmd(m0_cmd), .m0_addr(m0_addr),
      .m0_wvalid(m0_wvalid), .m0_wready(m0_wready), .m0_wlast(m0_wlast),
      .m0_wdata(m0_wdata), .m0_wmask(m0_wmask),
      .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rlast(m0_rlast), .m0_rdata(m0_rdata),
      .m1_cvalid(m1_cvalid), .m1_cready(m1_cready), .m1_cmd(m1_cmd), .m1_addr(m1_addr),
      .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_wlast(m1_wlast),
      .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
      .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rlast(m1_rlast), .m1_rdata(m1_rdata),
      .arb_cvalid(arb_cvalid), .dctl_cready(dctl_cready), .arb_cmd(arb_cmd), .arb_addr(arb_addr),
      .arb_wvalid(arb_wvalid), .dctl_wready(dctl_wready), .arb_wlast(arb_wlast),
      .arb_wdata(arb_wdata), .arb_wmask(arb_wmask),
      .dctl_rvalid(dctl_rvalid), .arb_rready(arb_rready), .dctl_rlast(dctl_rlast),
      .dctl_rdata(dctl_rdata), .dctl_error(dctl_error),
      .arb_grant(arb_grant), .arb_error(arb_error)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic cready_of(input int m);
      return (m == 0) ? m0_cready : m1_cready;
   endfunction
   function automatic logic wready_of(input int m);
      return (m == 0) ? m0_wready : m1_wready;
   endfunction
   function automatic logic rvalid_of(input int m);
      return (m == 0) ? m0_rvalid : m1_rvalid;
   endfunction
   function automatic logic rlast_of(input int m);
      return (m == 0) ? m0_rlast : m1_rlast;
   endfunction
   function automatic logic [31:0] rdata_of(input int m);
      return (m == 0) ? m0_rdata : m1_rdata;
   endfunction

   task automatic step();
      @(posedge clk_core);
      #1;
   endtask

   task automatic set_cmd(input int m, input logic v, input logic cmd, input logic [25:0] addr);
      if (m == 0) begin m0_cvalid = v; m0_cmd = cmd; m0_addr = addr; end
      else        begin m1_cvalid = v; m1_cmd = cmd; m1_addr = addr; end
   endtask

   task automatic set_w(input int m, input logic v, input logic last,
                        input logic [31:0] data, input logic [3:0] mask);
      if (m == 0) begin m0_wvalid = v; m0_wlast = last; m0_wdata = data; m0_wmask = mask; end
      else        begin m1_wvalid = v; m1_wlast = last; m1_wdata = data; m1_wmask = mask; end
   endtask

   // Entered one cycle after the grant edge (arbiter in CMD for requester m).
   task automatic burst_read(input int m, input int n, input logic [25:0] addr,
                             input logic [31:0] base, input logic err0, input int err_after);
      check_val("rd_grant", 32'(arb_grant), 32'(1) << m);
      check_val("rd_cvalid", 32'(arb_cvalid), 32'd1);
      check_val("rd_cmd", 32'(arb_cmd), 32'd1);
      check_val("rd_addr", 32'(arb_addr), 32'(addr));
      dctl_cready = 1'b1;
      #1;
      check_val("rd_cready", 32'(cready_of(m)), 32'd1);
      check_val("rd_other_cready", 32'(cready_of(1 - m)), 32'd0);
      step();
      dctl_cready = 1'b0;
      set_cmd(m, 1'b0, 1'b1, addr);
      for (int i = 0; i < n; i++) begin
         dctl_rvalid = 1'b1;
         dctl_rdata  = base + 32'(i);
         dctl_rlast  = (i == n - 1);
         #1;
         check_val("rd_rvalid", 32'(rvalid_of(m)), 32'd1);
         check_val("rd_rdata", rdata_of(m), base + 32'(i));
         check_val("rd_rlast", 32'(rlast_of(m)), (i == n - 1) ? 32'd1 : 32'd0);
         check_val("rd_other_rvalid", 32'(rvalid_of(1 - m)), 32'd0);
         check_val("rd_rready", 32'(arb_rready), 32'd1);
         step();
         check_val("rd_error", 32'(arb_error), (err0 || i >= err_after) ? 32'd1 : 32'd0);
      end
      dctl_rvalid = 1'b0;
      dctl_rlast  = 1'b0;
      check_val("rd_idle_grant", 32'(arb_grant), 32'd0);
      $display("[TB] read  m%0d addr=0x%07h beats=%0d", m, addr, n);
   endtask

   task automatic burst_write(input int m, input int n, input logic [25:0] addr,
                              input logic [31:0] base, input int stall_at, input int stall_len,
                              input logic err0, input int err_after);
      check_val("wr_grant", 32'(arb_grant), 32'(1) << m);
      check_val("wr_cvalid", 32'(arb_cvalid), 32'd1);
      check_val("wr_cmd", 32'(arb_cmd), 32'd0);
      check_val("wr_addr", 32'(arb_addr), 32'(addr));
      dctl_cready = 1'b1;
      #1;
      check_val("wr_cready", 32'(cready_of(m)), 32'd1);
      step();
      dctl_cready = 1'b0;
      dctl_wready = 1'b1;
      set_cmd(m, 1'b0, 1'b0, addr);
      for (int i = 0; i < n; i++) begin
         set_w(m, 1'b1, (i == n - 1), base + 32'(i), 4'hF);
         if (i == stall_at) begin
            dctl_wready = 1'b0;
            for (int s = 0; s < stall_len; s++) begin
               #1;
               check_val("wr_stall_wready", 32'(wready_of(m)), 32'd0);
               check_val("wr_stall_wvalid", 32'(arb_wvalid), 32'd1);
               check_val("wr_stall_grant", 32'(arb_grant), 32'(1) << m);
               step();
            end
            dctl_wready = 1'b1;
         end
         #1;
         check_val("wr_wready", 32'(wready_of(m)), 32'd1);
         check_val("wr_other_wready", 32'(wready_of(1 - m)), 32'd0);
         check_val("wr_wdata", arb_wdata, base + 32'(i));
         check_val("wr_wmask", 32'(arb_wmask), 32'hF);
         check_val("wr_wlast", 32'(arb_wlast), (i == n - 1) ? 32'd1 : 32'd0);
         step();
         check_val("wr_error", 32'(arb_error), (err0 || i >= err_after) ? 32'd1 : 32'd0);
      end
      set_w(m, 1'b0, 1'b0, 32'd0, 4'h0);
      check_val("wr_idle_grant", 32'(arb_grant), 32'd0);
      $display("[TB] write m%0d addr=0x%07h beats=%0d", m, addr, n);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      set_cmd(0, 1'b0, 1'b0, 26'd0);
      set_cmd(1, 1'b0, 1'b0, 26'd0);
      set_w(0, 1'b0, 1'b0, 32'd0, 4'h0);
      set_w(1, 1'b0, 1'b0, 32'd0, 4'h0);
      m0_rready = 1'b1; m1_rready = 1'b1;
      dctl_cready = 1'b0; dctl_wready = 1'b0; dctl_rvalid = 1'b0;
      dctl_rlast = 1'b0; dctl_rdata = 32'd0; dctl_error = 1'b0;

      // Reset state, with read data poking at the arbiter while reset is held.
      step();
      dctl_rvalid = 1'b1;
      #1;
      check_val("rst_grant", 32'(arb_grant), 32'd0);
      check_val("rst_cvalid", 32'(arb_cvalid), 32'd0);
      check_val("rst_m0_rvalid", 32'(m0_rvalid), 32'd0);
      check_val("rst_rready", 32'(arb_rready), 32'd0);
      step();
      check_val("rst_error", 32'(arb_error), 32'd0);
      dctl_rvalid = 1'b0;
      reset = 1'b0;
      $display("[TB] reset released");

      // m0 read at byte 0x100, 4 beats; prio becomes 1.
      set_cmd(0, 1'b1, 1'b1, 26'h040);
      step();
      burst_read(0, 4, 26'h040, 32'hA0, 1'b0, 1000);

      // Contention with prio = 1: m1 first, then m0 after one IDLE cycle.
      set_cmd(0, 1'b1, 1'b1, 26'h111);
      set_cmd(1, 1'b1, 1'b1, 26'h222);
      step();
      burst_read(1, 2, 26'h222, 32'hC0, 1'b0, 1000);
      check_val("turn_m0_cready", 32'(m0_cready), 32'd0);
      step();
      burst_read(0, 2, 26'h111, 32'hC8, 1'b0, 1000);

      // Contention straight from reset: m0, m1, m0.
      reset = 1'b1;
      step();
      reset = 1'b0;
      set_cmd(0, 1'b1, 1'b1, 26'h010);
      set_cmd(1, 1'b1, 1'b1, 26'h020);
      step();
      burst_read(0, 2, 26'h010, 32'h10, 1'b0, 1000);
      step();
      burst_read(1, 2, 26'h020, 32'h20, 1'b0, 1000);
      set_cmd(0, 1'b1, 1'b1, 26'h030);
      set_cmd(1, 1'b1, 1'b0, 26'h300);
      step();
      burst_read(0, 2, 26'h030, 32'h30, 1'b0, 1000);

      // Pending m1 write, 4 beats, controller stalls 3 cycles on beat 2.
      step();
      burst_write(1, 4, 26'h300, 32'hB0, 2, 3, 1'b0, 1000);
      check_val("clean_write_error", 32'(arb_error), 32'd0);

      // Odd-length m0 write: error after the 3rd beat, sticky afterwards.
      set_cmd(0, 1'b1, 1'b0, 26'h400);
      step();
      burst_write(0, 3, 26'h400, 32'hD0, -1, 0, 1'b0, 2);
      set_cmd(1, 1'b1, 1'b1, 26'h500);
      step();
      burst_read(1, 2, 26'h500, 32'hD8, 1'b1, 1000);
      reset = 1'b1;
      #1;
      check_val("async_clr_error", 32'(arb_error), 32'd0);
      step();
      reset = 1'b0;

      // 17-beat read overflows a 16-beat maximum on the last beat.
      set_cmd(0, 1'b1, 1'b1, 26'h600);
      step();
      burst_read(0, 17, 26'h600, 32'hE0, 1'b0, 16);
      reset = 1'b1;
      step();
      reset = 1'b0;

      // Stray read beat while idle.
      dctl_rvalid = 1'b1;
      #1;
      check_val("idle_m0_rvalid", 32'(m0_rvalid), 32'd0);
      check_val("idle_m1_rvalid", 32'(m1_rvalid), 32'd0);
      step();
      dctl_rvalid = 1'b0;
      check_val("idle_rvalid_error", 32'(arb_error), 32'd1);
      $display("[TB] stray rvalid in idle");

      // Async reset in the middle of an m1 write burst.
      set_cmd(1, 1'b1, 1'b0, 26'h700);
      step();
      dctl_cready = 1'b1;
      step();
      dctl_cready = 1'b0;
      set_cmd(1, 1'b0, 1'b0, 26'h700);
      dctl_wready = 1'b1;
      set_w(1, 1'b1, 1'b0, 32'hF0, 4'hF);
      #1;
      check_val("mid_wready", 32'(m1_wready), 32'd1);
      step();
      #2;
      reset = 1'b1;
      #1;
      check_val("arst_grant", 32'(arb_grant), 32'd0);
      check_val("arst_wready", 32'(m1_wready), 32'd0);
      check_val("arst_wvalid", 32'(arb_wvalid), 32'd0);
      check_val("arst_error", 32'(arb_error), 32'd0);
      step();
      set_w(1, 1'b0, 1'b0, 32'd0, 4'h0);
      dctl_wready = 1'b0;
      reset = 1'b0;
      $display("[TB] async reset mid write");

      set_cmd(1, 1'b1, 1'b1, 26'h080);
      step();
      burst_read(1, 2, 26'h080, 32'h55, 1'b0, 1000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
